systolic_act_skewer: RTL and testbench

- Feeds activations into the left edge of the systolic PE array.
- Accepts one N-lane activation vector per valid/ready handshake and buffers it in a small FIFO.
- Issues one vector per cycle with diagonal skew: lane i is delayed i extra cycles, so row i of the array sees its element aligned with the partial sums flowing down.
- After the last vector of a batch, injects N-1 zero cycles so that vector fully drains into the array, then pulses done.

---
 rtl/tpu_pkg.sv | 5 +
 rtl/systolic_act_skewer_if.sv | 10 +
 rtl/systolic_act_skewer_fifo.sv | 33 +++
 rtl/systolic_act_skewer.sv | 65 ++++++
 tb/tb_systolic_act_skewer.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared state encoding and defaults for the TPU datapath blocks
package tpu_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_STREAM = 2'd1, ST_FLUSH = 2'd2} state_t;
  localparam int DEF_DW = 8;
endpackage

// File: rtl/systolic_act_skewer_if.sv
// systolic_act_skewer_if: activation input handshake and skewed array-edge outputs
interface systolic_act_skewer_if import tpu_pkg::*; #(
  parameter int N = 4,
  parameter int DW = DEF_DW
);
  logic in_valid, in_ready, in_last, busy, done;
  logic [N*DW-1:0] in_data, out_data;
  modport master(output in_valid, in_data, in_last, input in_ready, out_data, busy, done);
  modport slave(input in_valid, in_data, in_last, output in_ready, out_data, busy, done);
endinterface

// File: rtl/systolic_act_skewer_fifo.sv
// sync_fifo: first-word-fall-through FIFO; push ignored when full, pop ignored when empty
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push;
  assign do_push = push && !full;
  assign empty = wp == rp;
  assign full = wp == {~rp[AW], rp[AW-1:0]};
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + (AW+1)'(1);
      if (pop && !empty) rp <= rp + (AW+1)'(1);
    end
endmodule

// File: rtl/systolic_act_skewer.sv
// systolic_act_skewer: buffers activation vectors and issues them diagonally skewed
// into the left edge of the PE array, draining each batch with N-1 zero cycles.
module systolic_act_skewer import tpu_pkg::*; #(
  parameter int N = 4,
  parameter int DW = DEF_DW,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  systolic_act_skewer_if.slave io
);
  localparam int W = N*DW+1;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [W-1:0] head;
  logic full, empty, pop, last_pop, done_q, done_n;
  logic [N*DW-1:0] issue, out_q;
  sync_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(io.in_valid && !full),
    .pop(pop),
    .din({io.in_last, io.in_data}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    pop = !empty && state != ST_FLUSH;
    last_pop = pop && head[W-1];
    issue = pop ? head[W-2:0] : '0;
    state_n = state == ST_FLUSH ? (cnt == CW'(1) ? ST_IDLE : ST_FLUSH)
            : last_pop ? (N == 1 ? ST_IDLE : ST_FLUSH)
            : pop ? ST_STREAM : state;
    cnt_n = (state != ST_FLUSH && state_n == ST_FLUSH) ? CW'(N-1)
          : state == ST_FLUSH ? cnt - CW'(1) : cnt;
    done_n = (state == ST_FLUSH && cnt == CW'(1)) || (last_pop && N == 1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      done_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      done_q <= done_n;
    end
  // lane i carries i extra registers so row i lags row 0 by i cycles
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] sr [i+1];
    always_ff @(posedge clk or posedge rst)
      if (rst) sr <= '{default: '0};
      else begin
        sr[0] <= issue[i*DW +: DW];
        for (int k = 1; k <= i; k++) sr[k] <= sr[k-1];
      end
    assign out_q[i*DW +: DW] = sr[i];
  end
  assign io.out_data = out_q;
  assign io.in_ready = !full;
  assign io.busy = state != ST_IDLE;
  assign io.done = done_q;
endmodule

// File: tb/tb_systolic_act_skewer.sv
// tb_systolic_act_skewer: directed checks of skew timing, batching, backpressure, reset and N=1
module tb_systolic_act_skewer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [31:0] iss [16];
  bit dn [16];
  bit bz [16];
  bit rd [16];
  bit sv [16];
  logic [32:0] sd [16];
  int ns;
  always #5 clk = ~clk;
  systolic_act_skewer_if #(.N(4), .DW(8)) io4 ();
  systolic_act_skewer_if #(.N(1), .DW(8)) io1 ();
  systolic_act_skewer #(.N(4), .DW(8), .DEPTH(4)) u4 (.clk(clk), .rst(rst), .io(io4));
  systolic_act_skewer #(.N(1), .DW(8), .DEPTH(4)) u1 (.clk(clk), .rst(rst), .io(io1));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic clr();
    for (int c = 0; c < 16; c++) begin
      iss[c] = '0;
      dn[c] = 0;
      bz[c] = 0;
      rd[c] = 1;
    end
    ns = 0;
  endtask
  task automatic add(input bit v, input bit l, input logic [31:0] d);
    sv[ns] = v;
    sd[ns] = {l, d};
    ns++;
  endtask
  function automatic logic [31:0] exp_out(int c);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++)
      if (c - i >= 0) r[i*8 +: 8] = iss[c-i][i*8 +: 8];
    return r;
  endfunction
  task automatic run(input string nm, input int ncyc);
    int si = 0;
    bit hs;
    for (int c = 0; c < ncyc; c++) begin
      io4.in_valid = si < ns && sv[si];
      {io4.in_last, io4.in_data} = si < ns ? sd[si] : '0;
      hs = io4.in_ready;
      @(posedge clk);
      #2;
      if (si < ns && (!sv[si] || hs)) si++;
      check($sformatf("%s out c%0d", nm, c), io4.out_data, exp_out(c));
      check($sformatf("%s done c%0d", nm, c), 32'(io4.done), 32'(dn[c]));
      check($sformatf("%s busy c%0d", nm, c), 32'(io4.busy), 32'(bz[c]));
      check($sformatf("%s rdy c%0d", nm, c), 32'(io4.in_ready), 32'(rd[c]));
    end
    io4.in_valid = 1'b0;
    io4.in_last = 1'b0;
  endtask
  initial begin
    io4.in_valid = 1'b0;
    io4.in_last = 1'b0;
    io4.in_data = '0;
    io1.in_valid = 1'b0;
    io1.in_last = 1'b0;
    io1.in_data = '0;
    #7;
    check("rst out", io4.out_data, 32'h0);
    check("rst busy", 32'(io4.busy), 32'h0);
    check("rst done", 32'(io4.done), 32'h0);
    #5 rst = 1'b0;
    #1 check("rst rdy", 32'(io4.in_ready), 32'h1);
    @(posedge clk);
    #2;
    clr();
    add(1, 1, 32'h04030201);
    iss[1] = 32'h04030201;
    dn[4] = 1;
    for (int c = 1; c <= 3; c++) bz[c] = 1;
    run("single", 7);
    clr();
    add(1, 0, 32'h10101010);
    add(1, 0, 32'h20202020);
    add(1, 0, 32'h30303030);
    add(1, 1, 32'h40404040);
    for (int j = 0; j < 4; j++) iss[1+j] = sd[j][31:0];
    dn[7] = 1;
    for (int c = 1; c <= 6; c++) bz[c] = 1;
    run("b2b", 10);
    clr();
    add(1, 1, 32'h0A0A0A0A);
    for (int k = 1; k <= 5; k++) add(1, k == 5, {4{4'(k), 4'h0}} | 32'h04030201);
    iss[1] = 32'h0A0A0A0A;
    for (int k = 1; k <= 5; k++) iss[4+k] = sd[k][31:0];
    dn[4] = 1;
    dn[12] = 1;
    for (int c = 1; c <= 11; c++) bz[c] = c != 4;
    rd[4] = 0;
    run("bp", 14);
    clr();
    add(1, 0, 32'hA4A3A2A1);
    add(0, 0, 32'h0);
    add(0, 0, 32'h0);
    add(1, 1, 32'hB4B3B2B1);
    iss[1] = 32'hA4A3A2A1;
    iss[4] = 32'hB4B3B2B1;
    dn[7] = 1;
    for (int c = 1; c <= 6; c++) bz[c] = 1;
    run("bubble", 10);
    io4.in_valid = 1'b1;
    io4.in_last = 1'b1;
    io4.in_data = 32'h04030201;
    @(posedge clk);
    #2;
    io4.in_last = 1'b0;
    io4.in_data = 32'hC4C3C2C1;
    @(posedge clk);
    #2;
    io4.in_data = 32'hD4D3D2D1;
    @(posedge clk);
    #2;
    io4.in_valid = 1'b0;
    check("prerst out", io4.out_data, 32'h00000200);
    rst = 1'b1;
    #1;
    check("midrst out", io4.out_data, 32'h0);
    check("midrst busy", 32'(io4.busy), 32'h0);
    check("midrst done", 32'(io4.done), 32'h0);
    #2 rst = 1'b0;
    #1 check("postrst rdy", 32'(io4.in_ready), 32'h1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #2;
      check($sformatf("postrst out c%0d", c), io4.out_data, 32'h0);
      check($sformatf("postrst done c%0d", c), 32'(io4.done), 32'h0);
      check($sformatf("postrst busy c%0d", c), 32'(io4.busy), 32'h0);
    end
    io1.in_valid = 1'b1;
    io1.in_last = 1'b1;
    io1.in_data = 8'h5A;
    @(posedge clk);
    #2;
    io1.in_valid = 1'b0;
    io1.in_last = 1'b0;
    check("n1 out c0", 32'(io1.out_data), 32'h0);
    check("n1 done c0", 32'(io1.done), 32'h0);
    @(posedge clk);
    #2;
    check("n1 out c1", 32'(io1.out_data), 32'h5A);
    check("n1 done c1", 32'(io1.done), 32'h1);
    check("n1 busy c1", 32'(io1.busy), 32'h0);
    @(posedge clk);
    #2;
    check("n1 out c2", 32'(io1.out_data), 32'h0);
    check("n1 done c2", 32'(io1.done), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
